dpe_seq_ctrl: RTL

- Sequencer for one DPE tile; drives its ena, reg_ctrl, load_sel and valid_a from an in-order command stream.
- Ping-pongs the two DSP weight buffers so weight loading for the next tile overlaps compute on the current one.
- Sits between the MVU instruction decoder (commands), the weight FIFO (din_b beats) and the VRF vector stream (din_a beats).

---
 rtl/dpe_seq_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dpe_seq_ctrl.sv
// Command sequencer for one DPE tile: ping-pong weight-buffer loading overlapped with vector compute.
// Optional stall counters are built only when DPE_SEQ_CTRL_PERF_EN is defined.
//
// Load engine   | meaning
// LD_IDLE       | no load in progress, LOAD may be accepted
// LD_ACTIVE     | streaming DOTW weight rows into buffer dpe_reg_ctrl
//
// Compute engine| meaning
// CMP_IDLE      | no compute in progress
// CMP_SWITCH    | one cycle, dpe_load_sel moves to the buffer being computed on
// CMP_STREAM    | accepting vectors until the command length is reached
// CMP_DRAIN     | waiting DRAIN cycles for DPE/reduction results, cmp_done on the last

module dpe_seq_ctrl #(
    parameter int DOTW  = 10,
    parameter int LENW  = 9,
    parameter int DRAIN = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic [LENW-1:0] cmd_len,
    input  logic            wt_valid,
    output logic            wt_ready,
    input  logic            vec_valid,
    output logic            vec_ready,
    output logic            dpe_ena,
    output logic            dpe_reg_ctrl,
    output logic            dpe_load_sel,
    output logic            dpe_valid_a,
    output logic            load_done,
    output logic            cmp_done,
    output logic            busy,
    output logic [31:0]     perf_vec_stall,
    output logic [31:0]     perf_wt_stall
);

    localparam int RW  = $clog2(DOTW + 1);
    localparam int DRW = $clog2(DRAIN + 1);

    typedef enum logic {
        LD_IDLE,
        LD_ACTIVE
    } ld_state_t;

    typedef enum logic [1:0] {
        CMP_IDLE,
        CMP_SWITCH,
        CMP_STREAM,
        CMP_DRAIN
    } cmp_state_t;

    ld_state_t       ld_state_q,   ld_state_d;
    logic [RW-1:0]   rows_left_q,  rows_left_d;
    logic            ld_buf_q,     ld_buf_d;
    logic            load_done_q,  load_done_d;
    logic            pending_q,    pending_d;
    logic            pend_buf_q,   pend_buf_d;
    logic            cur_valid_q,  cur_valid_d;
    logic            cur_buf_q,    cur_buf_d;
    cmp_state_t      cmp_state_q,  cmp_state_d;
    logic [LENW-1:0] vec_left_q,   vec_left_d;
    logic [DRW-1:0]  drain_left_q, drain_left_d;
    logic            load_sel_q,   load_sel_d;

    logic ld_idle;
    logic cmp_idle;
    logic load_ok;
    logic cmp_ok;
    logic acc_load;
    logic acc_cmp;
    logic wt_beat;
    logic vec_beat;

    // A COMPUTE needs a finished buffer: either a fresh one (pending) or the one already in use.
    assign ld_idle  = (ld_state_q == LD_IDLE);
    assign cmp_idle = (cmp_state_q == CMP_IDLE);
    assign load_ok  = ld_idle;
    assign cmp_ok   = cmp_idle && ld_idle && (pending_q || cur_valid_q);

    assign cmd_ready = cmd_valid && (cmd_op ? cmp_ok : load_ok);
    assign acc_load  = cmd_ready && !cmd_op;
    assign acc_cmp   = cmd_ready &&  cmd_op;

    assign wt_ready    = (ld_state_q == LD_ACTIVE);
    assign vec_ready   = (cmp_state_q == CMP_STREAM);
    assign wt_beat     = wt_valid && wt_ready;
    assign vec_beat    = vec_valid && vec_ready;
    assign dpe_ena     = wt_beat;
    assign dpe_valid_a = vec_beat;
    assign dpe_reg_ctrl = ld_buf_q;
    assign dpe_load_sel = load_sel_q;
    assign load_done   = load_done_q;
    assign cmp_done    = (cmp_state_q == CMP_DRAIN) && (drain_left_q == '0);
    assign busy        = !ld_idle || !cmp_idle;

    always_comb begin
        ld_state_d   = ld_state_q;
        rows_left_d  = rows_left_q;
        ld_buf_d     = ld_buf_q;
        load_done_d  = 1'b0;
        pending_d    = pending_q;
        pend_buf_d   = pend_buf_q;
        cur_valid_d  = cur_valid_q;
        cur_buf_d    = cur_buf_q;
        cmp_state_d  = cmp_state_q;
        vec_left_d   = vec_left_q;
        drain_left_d = drain_left_q;
        load_sel_d   = load_sel_q;

        // Load engine: a new LOAD always targets the buffer not selected for compute.
        if (acc_load) begin
            ld_state_d  = LD_ACTIVE;
            rows_left_d = RW'(DOTW - 1);
            ld_buf_d    = ~cur_buf_q;
            pending_d   = 1'b0;
        end else if (wt_beat) begin
            if (rows_left_q == '0) begin
                ld_state_d  = LD_IDLE;
                load_done_d = 1'b1;
                pending_d   = 1'b1;
                pend_buf_d  = ld_buf_q;
            end else begin
                rows_left_d = rows_left_q - RW'(1);
            end
        end

        if (acc_cmp && pending_q) begin
            cur_buf_d   = pend_buf_q;
            pending_d   = 1'b0;
            cur_valid_d = 1'b1;
        end

        unique case (cmp_state_q)
            CMP_IDLE: begin
                if (acc_cmp) begin
                    cmp_state_d = CMP_SWITCH;
                    vec_left_d  = cmd_len;
                end
            end
            CMP_SWITCH: begin
                load_sel_d = cur_buf_q;
                if (vec_left_q == '0) begin
                    cmp_state_d  = CMP_DRAIN;
                    drain_left_d = DRW'(DRAIN - 1);
                end else begin
                    cmp_state_d = CMP_STREAM;
                end
            end
            CMP_STREAM: begin
                if (vec_beat) begin
                    vec_left_d = vec_left_q - LENW'(1);
                    if (vec_left_q == LENW'(1)) begin
                        cmp_state_d  = CMP_DRAIN;
                        drain_left_d = DRW'(DRAIN - 1);
                    end
                end
            end
            CMP_DRAIN: begin
                if (drain_left_q == '0) begin
                    cmp_state_d = CMP_IDLE;
                end else begin
                    drain_left_d = drain_left_q - DRW'(1);
                end
            end
            default: cmp_state_d = CMP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_q   <= LD_IDLE;
            rows_left_q  <= '0;
            ld_buf_q     <= 1'b0;
            load_done_q  <= 1'b0;
            pending_q    <= 1'b0;
            pend_buf_q   <= 1'b0;
            cur_valid_q  <= 1'b0;
            cur_buf_q    <= 1'b1;
            cmp_state_q  <= CMP_IDLE;
            vec_left_q   <= '0;
            drain_left_q <= '0;
            load_sel_q   <= 1'b0;
        end else begin
            ld_state_q   <= ld_state_d;
            rows_left_q  <= rows_left_d;
            ld_buf_q     <= ld_buf_d;
            load_done_q  <= load_done_d;
            pending_q    <= pending_d;
            pend_buf_q   <= pend_buf_d;
            cur_valid_q  <= cur_valid_d;
            cur_buf_q    <= cur_buf_d;
            cmp_state_q  <= cmp_state_d;
            vec_left_q   <= vec_left_d;
            drain_left_q <= drain_left_d;
            load_sel_q   <= load_sel_d;
        end
    end

`ifdef DPE_SEQ_CTRL_PERF_EN
    logic [31:0] vec_stall_q, vec_stall_d;
    logic [31:0] wt_stall_q,  wt_stall_d;

    // Saturating counters so a long run never wraps back to a misleadingly small value.
    always_comb begin
        vec_stall_d = vec_stall_q;
        wt_stall_d  = wt_stall_q;
        if ((cmp_state_q == CMP_STREAM) && !vec_valid && (vec_stall_q != '1)) begin
            vec_stall_d = vec_stall_q + 32'd1;
        end
        if ((ld_state_q == LD_ACTIVE) && !wt_valid && (wt_stall_q != '1)) begin
            wt_stall_d = wt_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_stall_q <= '0;
            wt_stall_q  <= '0;
        end else begin
            vec_stall_q <= vec_stall_d;
            wt_stall_q  <= wt_stall_d;
        end
    end

    assign perf_vec_stall = vec_stall_q;
    assign perf_wt_stall  = wt_stall_q;
`else
    assign perf_vec_stall = 32'd0;
    assign perf_wt_stall  = 32'd0;
`endif

endmodule
